// File: rtl/sfq_mp_pkg.sv
// Shared types and helpers for the multiphase SFQ sequencer.
package sfq_mp_pkg;

   localparam int DEF_NPHASES = 4;
   localparam int DEF_DW      = 8;
   localparam int MAX_NPHASES = 16;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   // Decode a phase index into a strobe; callers truncate to their phase count.
   function automatic logic [MAX_NPHASES-1:0] phase_onehot(input logic [3:0] idx);
      return MAX_NPHASES'(1) << idx;
   endfunction

endpackage

// File: rtl/sfq_phase_ring.sv
// Phase counter with clear, advance-enable and a wrap pulse at the last phase.
module sfq_phase_ring #(
   parameter  int NPHASES = 4,
   localparam int PW      = $clog2(NPHASES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          adv,
   output logic [PW-1:0] phase_idx,
   output logic [PW-1:0] phase_nxt,
   output logic          wrap
);

   logic [PW-1:0] phase_q, phase_d;

   always_comb begin
      wrap    = adv && (phase_q == PW'(NPHASES - 1));
      phase_d = phase_q;
      if (clr) begin
         phase_d = '0;
      end else if (adv) begin
         phase_d = wrap ? '0 : phase_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase_idx = phase_q;
   assign phase_nxt = phase_d;

endmodule

// File: rtl/sfq_phase_scheduler.sv
// Multiphase SFQ sequencer: FSM, stage counter, depth capture and host strobes.
module sfq_phase_scheduler
   import sfq_mp_pkg::*;
#(
   parameter  int NPHASES = DEF_NPHASES,
   parameter  int DW      = DEF_DW,
   localparam int PW      = $clog2(NPHASES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DW-1:0]      depth,
   input  logic               hold,
   output logic [NPHASES-1:0] phase_en,
   output logic [PW-1:0]      phase_idx,
   output logic [DW-1:0]      stage_cnt,
   output logic               in_valid,
   output logic               out_valid,
   output logic               busy,
   output logic               done,
   output logic               err
);

   state_e              state_q, state_d;
   logic [DW-1:0]       depth_q, depth_d;
   logic [DW-1:0]       stage_q, stage_d;
   logic [NPHASES-1:0]  phase_en_q, phase_en_d;
   logic                in_valid_q, in_valid_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                ring_clr, ring_adv, ring_wrap;
   logic [PW-1:0]       phase_nxt;

   sfq_phase_ring #(.NPHASES(NPHASES)) u_ring (
      .clk       (clk),
      .rst_n     (rst),
      .clr       (ring_clr),
      .adv       (ring_adv),
      .phase_idx (phase_idx),
      .phase_nxt (phase_nxt),
      .wrap      (ring_wrap)
   );

   always_comb begin
      state_d     = state_q;
      depth_d     = depth_q;
      stage_d     = stage_q;
      phase_en_d  = '0;
      in_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      ring_clr    = 1'b0;
      ring_adv    = 1'b0;
      case (state_q)
         RUN: begin
            busy_d = 1'b1;
            if (out_valid_q) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               // A phase is consumed only once its strobe has been issued, so held cycles re-present the same position.
               ring_adv = (phase_en_q != '0);
               stage_d  = stage_q + DW'(ring_wrap);
               if (!hold) begin
                  phase_en_d  = NPHASES'(phase_onehot(4'(phase_nxt)));
                  in_valid_d  = (phase_nxt == '0) && (stage_d == '0);
                  out_valid_d = (phase_nxt == PW'(NPHASES - 1)) && (stage_d == depth_q - DW'(1));
               end
            end
         end
         default: begin
            if (state_q == DONE) begin
               state_d = IDLE;
            end
            if (start && (depth != '0)) begin
               state_d    = RUN;
               depth_d    = depth;
               stage_d    = '0;
               ring_clr   = 1'b1;
               phase_en_d = NPHASES'(1);
               in_valid_d = 1'b1;
               busy_d     = 1'b1;
            end else if (start) begin
               err_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         depth_q     <= '0;
         stage_q     <= '0;
         phase_en_q  <= '0;
         in_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         depth_q     <= depth_d;
         stage_q     <= stage_d;
         phase_en_q  <= phase_en_d;
         in_valid_q  <= in_valid_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign phase_en  = phase_en_q;
   assign stage_cnt = stage_q;
   assign in_valid  = in_valid_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_sfq_phase_scheduler.sv
// Directed bench for sfq_phase_scheduler at NPHASES=4, 2 and 16.
module tb_sfq_phase_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       st2 = 1'b0;
   logic       st16 = 1'b0;
   logic       hold = 1'b0;
   logic [7:0] depth = '0;

   logic [3:0]  pe4;  logic [1:0] idx4; logic [7:0] stg4;
   logic        iv4, ov4, bz4, dn4, er4;
   logic [1:0]  pe2;  logic       idx2; logic [7:0] stg2;
   logic        iv2, ov2, bz2, dn2, er2;
   logic [15:0] pe16; logic [3:0] idx16; logic [7:0] stg16;
   logic        iv16, ov16, bz16, dn16, er16;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sfq_phase_scheduler #(.NPHASES(4), .DW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .depth(depth), .hold(hold),
      .phase_en(pe4), .phase_idx(idx4), .stage_cnt(stg4), .in_valid(iv4),
      .out_valid(ov4), .busy(bz4), .done(dn4), .err(er4));

   sfq_phase_scheduler #(.NPHASES(2), .DW(8)) dut2 (
      .clk(clk), .rst(rst), .start(st2), .depth(depth), .hold(hold),
      .phase_en(pe2), .phase_idx(idx2), .stage_cnt(stg2), .in_valid(iv2),
      .out_valid(ov2), .busy(bz2), .done(dn2), .err(er2));

   sfq_phase_scheduler #(.NPHASES(16), .DW(8)) dut16 (
      .clk(clk), .rst(rst), .start(st16), .depth(depth), .hold(hold),
      .phase_en(pe16), .phase_idx(idx16), .stage_cnt(stg16), .in_valid(iv16),
      .out_valid(ov16), .busy(bz16), .done(dn16), .err(er16));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Packed view of the NPHASES=4 instance: {phase_en, in_valid, out_valid, busy, done, err}.
   task automatic chk4(input string tag, input logic [3:0] pe, input logic iv, input logic ov,
                       input logic bz, input logic dn, input logic er);
      chk(tag, 32'({pe4, iv4, ov4, bz4, dn4, er4}), 32'({pe, iv, ov, bz, dn, er}));
   endtask

   initial begin
      int hold_pe [12] = '{1, 2, 0, 0, 0, 4, 8, 1, 2, 4, 8, 0};
      int strobes;
      int s2, s16, o2, o16, mx2, mx16, oh_bad, n;
      bit d2, d16;
      logic [3:0] e;

      // reset
      #12;
      chk4("reset outputs", 4'd0, 0, 0, 0, 0, 0);
      chk("reset idx/stage", 32'({idx4, stg4}), 32'd0);
      chk("reset other instances", 32'({pe2, bz2, pe16, bz16}), 32'd0);
      tick;
      rst = 1'b1;
      tick;
      chk4("idle after reset", 4'd0, 0, 0, 0, 0, 0);

      // single pass, depth 3; depth change and start during RUN must be ignored
      depth = 8'd3;
      start = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         tick;
         e = (c <= 12) ? (4'b0001 << ((c - 1) % 4)) : 4'd0;
         chk4($sformatf("pass1 c%0d", c), e, c == 1, c == 12, c <= 12, c == 13, 0);
         if (c <= 12) begin
            chk($sformatf("pass1 pos c%0d", c), 32'({stg4, 6'd0, idx4}),
                32'({8'((c - 1) / 4), 6'd0, 2'((c - 1) % 4)}));
         end
         if (c == 1) depth = 8'd9;
         start = (c == 3);
      end
      tick;
      chk4("pass1 back to idle", 4'd0, 0, 0, 0, 0, 0);

      // hold for three cycles at stage 0, phase 2
      depth = 8'd2;
      start = 1'b1;
      strobes = 0;
      for (int c = 1; c <= 12; c++) begin
         tick;
         start = 1'b0;
         if (pe4 != 4'd0) strobes++;
         chk4($sformatf("hold c%0d", c), 4'(hold_pe[c - 1]), c == 1, c == 11, c <= 11, c == 12, 0);
         if (c >= 3 && c <= 6) chk($sformatf("hold frozen idx c%0d", c), 32'({stg4, idx4}), 32'd2);
         if (c == 2) hold = 1'b1;
         if (c == 5) hold = 1'b0;
      end
      chk("hold strobe count", 32'(strobes), 32'd8);
      tick;

      // zero depth rejected
      depth = 8'd0;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk4("zero depth err", 4'd0, 0, 0, 0, 0, 1);
      for (int c = 1; c <= 3; c++) begin
         tick;
         chk4($sformatf("zero depth after c%0d", c), 4'd0, 0, 0, 0, 0, 0);
      end

      // back-to-back passes with start held, depth 1
      depth = 8'd1;
      start = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         int p;
         tick;
         p = (c - 1) % 5;
         e = (p < 4) ? (4'b0001 << p) : 4'd0;
         chk4($sformatf("b2b c%0d", c), e, p == 0, p == 3, p < 4, p == 4, 0);
      end
      start = 1'b0;
      tick;
      chk4("b2b idle", 4'd0, 0, 0, 0, 0, 0);

      // reset mid-run at stage 2, phase 1
      depth = 8'd5;
      start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick;
         start = 1'b0;
      end
      chk("midrun pos", 32'({bz4, stg4, 6'd0, idx4}), 32'({1'b1, 8'd2, 6'd0, 2'd1}));
      #2;
      rst = 1'b0;
      #1;
      chk4("midrun reset immediate", 4'd0, 0, 0, 0, 0, 0);
      chk("midrun reset idx/stage", 32'({idx4, stg4}), 32'd0);
      tick;
      tick;
      chk4("midrun reset held", 4'd0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick;
         chk4($sformatf("post reset idle c%0d", c), 4'd0, 0, 0, 0, 0, 0);
      end
      depth = 8'd1;
      start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick;
         start = 1'b0;
         e = (c <= 4) ? (4'b0001 << (c - 1)) : 4'd0;
         chk4($sformatf("post reset run c%0d", c), e, c == 1, c == 4, c <= 4, c == 5, 0);
      end

      // NPHASES=2, depth 1: in_valid and out_valid on different phases
      depth = 8'd1;
      st2 = 1'b1;
      tick;
      st2 = 1'b0;
      chk("n2 d1 c1", 32'({pe2, iv2, ov2, bz2}), 32'({2'b01, 1'b1, 1'b0, 1'b1}));
      tick;
      chk("n2 d1 c2", 32'({pe2, iv2, ov2, bz2}), 32'({2'b10, 1'b0, 1'b1, 1'b1}));
      tick;
      chk("n2 d1 done", 32'({pe2, bz2, dn2}), 32'({2'b00, 1'b0, 1'b1}));
      tick;

      // full-depth sweep on the 2- and 16-phase instances
      depth = 8'd255;
      st2 = 1'b1;
      st16 = 1'b1;
      s2 = 0; s16 = 0; o2 = 0; o16 = 0; mx2 = 0; mx16 = 0; oh_bad = 0; n = 0;
      d2 = 1'b0; d16 = 1'b0;
      tick;
      st2 = 1'b0;
      st16 = 1'b0;
      while (!(d2 && d16) && n < 5000) begin
         if (pe2 != '0) begin
            s2++;
            if (pe2 != (2'b01 << idx2)) oh_bad++;
         end
         if (pe16 != '0) begin
            s16++;
            if (pe16 != (16'h0001 << idx16)) oh_bad++;
         end
         if (ov2) o2++;
         if (ov16) o16++;
         if (int'(stg2) > mx2) mx2 = int'(stg2);
         if (int'(stg16) > mx16) mx16 = int'(stg16);
         if (dn2) d2 = 1'b1;
         if (dn16) d16 = 1'b1;
         n++;
         tick;
      end
      chk("sweep done seen", 32'({d2, d16}), 32'd3);
      chk("sweep n2 strobes", 32'(s2), 32'd510);
      chk("sweep n16 strobes", 32'(s16), 32'd4080);
      chk("sweep n2 max stage", 32'(mx2), 32'd254);
      chk("sweep n16 max stage", 32'(mx16), 32'd254);
      chk("sweep n2 out_valid count", 32'(o2), 32'd1);
      chk("sweep n16 out_valid count", 32'(o16), 32'd1);
      chk("sweep one-hot", 32'(oh_bad), 32'd0);
      chk("sweep idle", 32'({bz2, bz16, pe2, pe16}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
